// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the command, ALU-side and result signals of the ALU command sequencer.
// The sequencer connects through the slave modport; its environment drives the master side.
interface alu_cmd_sequencer_if;
   // Command channel from upstream
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_x;
   logic [7:0]  cmd_y;
   // Downstream ALU control and data
   logic        alu_rst;
   logic        alu_start;
   logic [1:0]  alu_op;
   logic [7:0]  alu_inbus;
   logic        alu_done;
   logic [15:0] alu_outbus;
   // Result channel
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic        res_timeout;
   // Status
   logic        busy;

   modport slave (
      input  cmd_valid, cmd_op, cmd_x, cmd_y, alu_done, alu_outbus, res_ready,
      output cmd_ready, alu_rst, alu_start, alu_op, alu_inbus,
             res_valid, res_data, res_timeout, busy
   );

   modport master (
      output cmd_valid, cmd_op, cmd_x, cmd_y, alu_done, alu_outbus, res_ready,
      input  cmd_ready, alu_rst, alu_start, alu_op, alu_inbus,
             res_valid, res_data, res_timeout, busy
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Sequences one ALU command at a time: clear the ALU, present X with start for two
// cycles, present Y while waiting for done (or a timeout), then hold the result until
// downstream takes it. All outputs come from state and registers only.
module alu_cmd_sequencer #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_cmd_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_LOAD_X = 3'd2,
      S_WAIT   = 3'd3,
      S_RESULT = 3'd4
   } state_t;

   // Last counter value before the limit is reached; a WAIT cycle seen with this value
   // and no done is the final allowed WAIT cycle.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 32'd1);

   state_t      state_q,    state_d;
   logic        load_2nd_q, load_2nd_d;   // second LOAD_X cycle in progress
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [1:0]  op_q,       op_d;
   logic [7:0]  x_q,        x_d;
   logic [7:0]  y_q,        y_d;
   logic [15:0] res_data_q, res_data_d;
   logic        res_to_q,   res_to_d;

   // State and datapath registers with asynchronous reset to the idle/cleared condition
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         load_2nd_q <= 1'b0;
         wait_cnt_q <= 8'd0;
         op_q       <= 2'b00;
         x_q        <= 8'h00;
         y_q        <= 8'h00;
         res_data_q <= 16'h0000;
         res_to_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         load_2nd_q <= load_2nd_d;
         wait_cnt_q <= wait_cnt_d;
         op_q       <= op_d;
         x_q        <= x_d;
         y_q        <= y_d;
         res_data_q <= res_data_d;
         res_to_q   <= res_to_d;
      end
   end

   // Next-state and datapath update: command latch, LOAD_X length, wait/timeout, result capture
   always_comb begin
      state_d    = state_q;
      load_2nd_d = load_2nd_q;
      wait_cnt_d = wait_cnt_q;
      op_d       = op_q;
      x_d        = x_q;
      y_d        = y_q;
      res_data_d = res_data_q;
      res_to_d   = res_to_q;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               op_d    = bus.cmd_op;
               x_d     = bus.cmd_x;
               y_d     = bus.cmd_y;
               state_d = S_CLEAR;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CLEAR: begin
            load_2nd_d = 1'b0;
            state_d    = S_LOAD_X;
         end
         S_LOAD_X: begin
            if (load_2nd_q) begin
               wait_cnt_d = 8'd0;
               state_d    = S_WAIT;
            end else begin
               load_2nd_d = 1'b1;
            end
         end
         S_WAIT: begin
            // done takes priority over the timeout in the same cycle
            if (bus.alu_done) begin
               res_data_d = bus.alu_outbus;
               res_to_d   = 1'b0;
               state_d    = S_RESULT;
            end else if (wait_cnt_q == WAIT_LAST) begin
               wait_cnt_d = wait_cnt_q + 8'd1;
               res_data_d = 16'h0000;
               res_to_d   = 1'b1;
               state_d    = S_RESULT;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         S_RESULT: begin
            if (bus.res_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESULT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from the current state and latched operands
   always_comb begin
      bus.cmd_ready = 1'b0;
      bus.busy      = 1'b1;
      bus.alu_rst   = 1'b0;
      bus.alu_start = 1'b0;
      bus.alu_op    = 2'b00;
      bus.alu_inbus = 8'h00;
      bus.res_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            bus.cmd_ready = 1'b1;
            bus.busy      = 1'b0;
         end
         S_CLEAR: begin
            bus.alu_rst = 1'b1;
            bus.alu_op  = op_q;
         end
         S_LOAD_X: begin
            bus.alu_start = 1'b1;
            bus.alu_op    = op_q;
            bus.alu_inbus = x_q;
         end
         S_WAIT: begin
            bus.alu_op    = op_q;
            bus.alu_inbus = y_q;
         end
         S_RESULT: begin
            bus.res_valid = 1'b1;
         end
         default: begin
            bus.busy = 1'b1;
         end
      endcase
   end

   assign bus.res_data    = res_data_q;
   assign bus.res_timeout = res_to_q;

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 64, meaning: max cycles spent in WAIT before abort; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered by upstream.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_op  input  2  ALU opcode for this command.
REQ-007 cmd_x  input  8  first operand.
REQ-008 cmd_y  input  8  second operand.
REQ-009 alu_rst  output  1  reset pulse to the downstream ALU.
REQ-010 alu_start  output  1  ALU start strobe.
REQ-011 alu_op  output  2  opcode presented to the ALU.
REQ-012 alu_inbus  output  8  operand bus to the ALU.
REQ-013 alu_done  input  1  ALU completion indication (decoded by integrator from ALU state).
REQ-014 alu_outbus  input  16  ALU result.
REQ-015 res_valid  output  1  result available.
REQ-016 res_ready  input  1  downstream accepts result.
REQ-017 res_data  output  16  captured result.
REQ-018 res_timeout  output  1  result is an abort, not an ALU result.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, CLEAR, LOAD_X, WAIT, RESULT; all outputs SHALL be registered or decoded from state/registers only (no combinational path from inputs to outputs).
REQ-021 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1, latching cmd_op, cmd_x, cmd_y and moving to CLEAR.
REQ-022 cmd_valid while not in IDLE SHALL be ignored; no command is buffered.
REQ-023 CLEAR SHALL last exactly 1 cycle with alu_rst=1, alu_start=0, then go to LOAD_X.
REQ-024 LOAD_X SHALL last exactly 2 cycles with alu_start=1, alu_inbus=latched x, then go to WAIT.
REQ-025 In WAIT alu_start SHALL be 0 and alu_inbus SHALL hold latched y for the whole state.
REQ-026 alu_op SHALL equal the latched opcode from CLEAR through WAIT inclusive; 2'b00 in IDLE and RESULT.
REQ-027 alu_inbus SHALL be 8'h00 in IDLE, CLEAR and RESULT.
REQ-028 An 8-bit wait counter SHALL clear on entering WAIT and increment each WAIT cycle without alu_done.
REQ-029 alu_done=1 in a WAIT cycle SHALL capture alu_outbus into res_data, clear res_timeout, move to RESULT; alu_done is sampled no earlier than the first WAIT cycle.
REQ-030 If the counter reaches TIMEOUT with alu_done=0, the FSM SHALL move to RESULT with res_data=16'h0000, res_timeout=1.
REQ-031 alu_done and counter==TIMEOUT in the same cycle: done SHALL win (normal result).
REQ-032 alu_done outside WAIT SHALL be ignored.
REQ-033 res_valid SHALL be 1 exactly in RESULT; res_data and res_timeout SHALL stay stable while res_valid=1 and res_ready=0.
REQ-034 res_valid=1 and res_ready=1 on an edge SHALL return to IDLE; the next command is accepted no earlier than the following cycle.
REQ-035 Minimum latency, accept edge to res_valid high: 1 (CLEAR) + 2 (LOAD_X) + N WAIT cycles, N>=1.

Reset
REQ-036 rst=1 SHALL immediately force IDLE regardless of clock, from any state including mid-transaction.
REQ-037 Reset values: cmd_ready=1, busy=0, alu_rst=0, alu_start=0, alu_op=2'b00, alu_inbus=8'h00, res_valid=0, res_data=16'h0000, res_timeout=0, counter=0, latched operands=0.
REQ-038 A command in progress at reset SHALL be discarded without producing a result.

Verification
REQ-039 Add: cmd_op=2'b10, x=5, y=3; alu_done pulsed 10th WAIT cycle with alu_outbus=16'h0008 -> alu_rst 1 cycle, alu_start 2 cycles with inbus=5, inbus=3 in WAIT, res_data=16'h0008, res_timeout=0.
REQ-040 Timeout: TIMEOUT=16, x=14, y=52, alu_done held 0 -> res_valid after 16 WAIT cycles, res_data=16'h0000, res_timeout=1.
REQ-041 Back-pressure: res_ready=0 for 5 cycles after res_valid -> res_data/res_timeout stable, cmd_ready=0, second cmd_valid not accepted until after res handshake.
REQ-042 Reset mid-WAIT: rst asserted asynchronously between edges -> outputs at reset values immediately, no res_valid after release, next command processed normally.
REQ-043 Stray done: alu_done=1 in IDLE and during LOAD_X -> ignored; result only from done in WAIT.
REQ-044 Tie: TIMEOUT=8, alu_done=1 in the cycle counter==8 with alu_outbus=16'h1234 -> res_data=16'h1234, res_timeout=0.
